// File: rtl/systolic_skew_feeder_if.sv
// Row-vector input stream for systolic_skew_feeder.
//   in_valid     - beat valid (master -> feeder)
//   in_ready     - feeder can take the beat (feeder -> master)
//   in_data      - one tile row; element i at [i*DATA_SIZE +: DATA_SIZE]
//   in_last      - final beat of the current tile
//   in_transpose - drain mode, taken from the first beat of a tile
interface systolic_skew_feeder_if #(
  parameter int DATA_SIZE = 8,
  parameter int MAC_WIDTH = 4
);
  logic                           in_valid;
  logic                           in_ready;
  logic [DATA_SIZE*MAC_WIDTH-1:0] in_data;
  logic                           in_last;
  logic                           in_transpose;

  modport master (output in_valid, in_data, in_last, in_transpose, input in_ready);
  modport slave  (input in_valid, in_data, in_last, in_transpose, output in_ready);
endinterface

// File: rtl/systolic_skew_feeder.sv
// Input-staging feeder for the systolic MAC array edge.
// Tiles of MAC_WIDTH x MAC_WIDTH elements arrive one row per beat, land in a
// ping-pong tile buffer, and are drained one vector per cycle (optionally
// transposed) through a triangular delay network so lane i lags lane 0 by i.
//   clk, rst_n - rising-edge clock, asynchronous active-low reset
//   in_if      - row-vector input stream (slave side)
//   flush      - discard buffered tiles that have not started draining
//   out_data   - skewed lane data, lane i at [i*DATA_SIZE +: DATA_SIZE]
//   out_valid  - per-lane valid
//   tile_done  - pulse when lane N-1 presents the last element of a tile
//
// bank state | meaning
// B_EMPTY    | free, accepts the first beat of a new tile
// B_FILLING  | at least one row written, tile not yet closed
// B_FULL     | tile closed, waiting for the read side
// B_DRAINING | rows being loaded into the skew network
module systolic_skew_feeder #(
  parameter int DATA_SIZE = 8,
  parameter int MAC_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  systolic_skew_feeder_if.slave          in_if,
  input  logic                           flush,
  output logic [DATA_SIZE*MAC_WIDTH-1:0] out_data,
  output logic [MAC_WIDTH-1:0]           out_valid,
  output logic                           tile_done
);
  localparam int N  = MAC_WIDTH;
  localparam int DW = DATA_SIZE;
  localparam int RW = $clog2(N);
  localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_st_t;

  bank_st_t      bank_q [2];
  bank_st_t      bank_d [2];
  logic [DW-1:0] mem_q [2][N][N];
  logic [DW-1:0] mem_d [2][N][N];
  logic [1:0]    tr_q, tr_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic [RW-1:0] wr_row_q, wr_row_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [RW-1:0] rd_row_q, rd_row_d;
  logic          drain_q, drain_d;
  logic [N-1:0]  tok_q, tok_d;

  logic in_ready;
  logic accept;
  logic close;
  logic load;
  logic load_last;

  // Driven from registered bank state only, so a bank freed at an edge
  // starts accepting one cycle later.
  assign in_ready = rst_n & ((bank_q[wr_ptr_q] == B_EMPTY) |
                             (bank_q[wr_ptr_q] == B_FILLING));
  assign in_if.in_ready = in_ready;
  assign tile_done = tok_q[N-1];

  always_comb begin
    bank_d   = bank_q;
    mem_d    = mem_q;
    tr_d     = tr_q;
    wr_ptr_d = wr_ptr_q;
    wr_row_d = wr_row_q;
    rd_ptr_d = rd_ptr_q;
    rd_row_d = rd_row_q;
    drain_d  = drain_q;

    accept    = in_if.in_valid & in_ready & ~flush;
    close     = in_if.in_last | (wr_row_q == LAST_ROW);
    // A FULL bank is only picked up between drains or right after the last
    // row of the current one; rd_row_q is 0 whenever no drain is active.
    load      = drain_q | ((bank_q[rd_ptr_q] == B_FULL) & ~flush);
    load_last = load & (rd_row_q == LAST_ROW);
    tok_d     = {tok_q[N-2:0], load_last};

    if (accept) begin
      for (int r = 0; r < N; r++) begin
        if (RW'(r) == wr_row_q) begin
          for (int c = 0; c < N; c++) mem_d[wr_ptr_q][r][c] = in_if.in_data[c*DW +: DW];
        end else if (close && (RW'(r) > wr_row_q)) begin
          // early close: remaining rows drain as zeros
          for (int c = 0; c < N; c++) mem_d[wr_ptr_q][r][c] = '0;
        end
      end
      if (wr_row_q == '0) tr_d[wr_ptr_q] = in_if.in_transpose;
      if (close) begin
        bank_d[wr_ptr_q] = B_FULL;
        wr_row_d         = '0;
        wr_ptr_d         = ~wr_ptr_q;
      end else begin
        bank_d[wr_ptr_q] = B_FILLING;
        wr_row_d         = wr_row_q + 1'b1;
      end
    end

    if (load) begin
      if (load_last) begin
        bank_d[rd_ptr_q] = B_EMPTY;
        rd_ptr_d         = ~rd_ptr_q;
        rd_row_d         = '0;
        drain_d          = 1'b0;
      end else begin
        bank_d[rd_ptr_q] = B_DRAINING;
        rd_row_d         = rd_row_q + 1'b1;
        drain_d          = 1'b1;
      end
    end

    if (flush) begin
      for (int b = 0; b < 2; b++) begin
        if ((bank_q[b] == B_FILLING) || (bank_q[b] == B_FULL)) bank_d[b] = B_EMPTY;
      end
      wr_row_d = '0;
      if (bank_q[0] == B_DRAINING)      wr_ptr_d = 1'b1;
      else if (bank_q[1] == B_DRAINING) wr_ptr_d = 1'b0;
      else                              wr_ptr_d = wr_ptr_q;
      // With nothing draining the read side must follow the write side,
      // otherwise it would wait on a bank that was just emptied.
      if (!drain_q) rd_ptr_d = wr_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q[0] <= B_EMPTY;
      bank_q[1] <= B_EMPTY;
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++) mem_q[b][r][c] <= '0;
      tr_q     <= '0;
      wr_ptr_q <= 1'b0;
      wr_row_q <= '0;
      rd_ptr_q <= 1'b0;
      rd_row_q <= '0;
      drain_q  <= 1'b0;
      tok_q    <= '0;
    end else begin
      bank_q   <= bank_d;
      mem_q    <= mem_d;
      tr_q     <= tr_d;
      wr_ptr_q <= wr_ptr_d;
      wr_row_q <= wr_row_d;
      rd_ptr_q <= rd_ptr_d;
      rd_row_q <= rd_row_d;
      drain_q  <= drain_d;
      tok_q    <= tok_d;
    end
  end

  // Lane i: stage 0 is the drain vector element, then i more registers.
  // Idle stages carry zero so the lane output needs no masking.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DW-1:0] sr_q [i+1];
    logic [DW-1:0] sr_d [i+1];
    logic [i:0]    sv_q, sv_d;
    logic [DW-1:0] elem;

    always_comb begin
      elem = tr_q[rd_ptr_q] ? mem_q[rd_ptr_q][i][rd_row_q] : mem_q[rd_ptr_q][rd_row_q][i];
      sr_d = sr_q;
      sv_d = sv_q;
      sr_d[0] = load ? elem : '0;
      sv_d[0] = load;
      for (int k = 1; k <= i; k++) begin
        sr_d[k] = sr_q[k-1];
        sv_d[k] = sv_q[k-1];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k <= i; k++) sr_q[k] <= '0;
        sv_q <= '0;
      end else begin
        sr_q <= sr_d;
        sv_q <= sv_d;
      end
    end

    assign out_data[i*DW +: DW] = sr_q[i];
    assign out_valid[i]         = sv_q[i];
  end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
module tb_systolic_skew_feeder;
  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic [N*DW-1:0] out_data;
  logic [N-1:0]    out_valid;
  logic            tile_done;

  systolic_skew_feeder_if #(.DATA_SIZE(DW), .MAC_WIDTH(N)) bus ();

  systolic_skew_feeder #(.DATA_SIZE(DW), .MAC_WIDTH(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_if     (bus),
    .flush     (flush),
    .out_data  (out_data),
    .out_valid (out_valid),
    .tile_done (tile_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 0;
  int stalls = 0;
  int v0_cnt = 0;
  int td_cnt = 0;

  // expected tiles: start = cycle when lane 0 shows row 0
  int ntiles = 0;
  int last_start = -100;
  int t_start [16];
  int t_tag   [16];
  int t_rows  [16];
  bit t_tr    [16];

  function automatic logic [7:0] elem(int tag, int r, int c);
    return 8'(64*tag + 16*(r+1) + (c+1));
  endfunction

  function automatic logic [N*DW-1:0] rowvec(int tag, int r);
    logic [N*DW-1:0] v;
    for (int c = 0; c < N; c++) v[c*DW +: DW] = elem(tag, r, c);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_cycle();
    logic [N*DW-1:0] ed;
    logic [N-1:0]    ev;
    logic            etd;
    int r;
    ed = '0; ev = '0; etd = 1'b0;
    for (int k = 0; k < ntiles; k++) begin
      for (int i = 0; i < N; i++) begin
        r = cyc - t_start[k] - i;
        if (r >= 0 && r < N) begin
          ev[i] = 1'b1;
          if (t_tr[k]) ed[i*DW +: DW] = (i < t_rows[k]) ? elem(t_tag[k], i, r) : 8'h00;
          else         ed[i*DW +: DW] = (r < t_rows[k]) ? elem(t_tag[k], r, i) : 8'h00;
        end
      end
      if (cyc == t_start[k] + 2*N - 2) etd = 1'b1;
    end
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("out_data", 32'(out_data), 32'(ed));
    chk("tile_done", 32'(tile_done), 32'(etd));
    if (out_valid[0]) v0_cnt++;
    if (tile_done) td_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (mon_en) check_cycle();
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    repeat (n) tick();
  endtask

  task automatic add_tile(input int tag, input int rows, input bit tr);
    int s;
    s = (cyc + 1 > last_start + N) ? cyc + 1 : last_start + N;
    t_start[ntiles] = s;
    t_tag[ntiles]   = tag;
    t_rows[ntiles]  = rows;
    t_tr[ntiles]    = tr;
    ntiles++;
    last_start = s;
  endtask

  task automatic send_beat(input int tag, input int b, input bit last, input bit tr);
    bit rdy;
    bit done;
    int waits;
    bus.in_valid     = 1'b1;
    bus.in_data      = rowvec(tag, b);
    bus.in_last      = last;
    bus.in_transpose = tr;
    done = 0;
    waits = 0;
    while (!done) begin
      rdy = bus.in_ready;
      tick();
      if (rdy) done = 1;
      else begin
        stalls++;
        waits++;
        if (waits > 40) begin
          chk("ready_timeout", 32'(bus.in_ready), 32'(1));
          done = 1;
        end
      end
    end
  endtask

  task automatic send_tile(input int tag, input int nbeats, input bit tr, input bit record);
    for (int b = 0; b < nbeats; b++) send_beat(tag, b, (b == nbeats - 1), tr);
    if (record) add_tile(tag, nbeats, tr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.in_transpose = 1'b0;
    #2;
    chk("rst_in_ready", 32'(bus.in_ready), 32'(0));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_data", 32'(out_data), 32'(0));
    chk("rst_tile_done", 32'(tile_done), 32'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(bus.in_ready), 32'(1));
    mon_en = 1;

    // single tile, normal order
    td_cnt = 0;
    send_tile(0, 4, 1'b0, 1'b1);
    idle(10);
    chk("t1_done_cnt", 32'(td_cnt), 32'(1));

    // single tile, transposed
    send_tile(0, 4, 1'b1, 1'b1);
    idle(10);

    // three tiles streamed with in_valid held high
    stalls = 0; v0_cnt = 0; td_cnt = 0;
    send_tile(0, 4, 1'b0, 1'b1);
    send_tile(1, 4, 1'b1, 1'b1);
    send_tile(2, 4, 1'b0, 1'b1);
    idle(14);
    chk("stream_stalls", 32'(stalls), 32'(0));
    chk("stream_v0_cnt", 32'(v0_cnt), 32'(12));
    chk("stream_done_cnt", 32'(td_cnt), 32'(3));

    // short tile (last on beat 1), then a full tile into the other bank
    send_tile(1, 2, 1'b0, 1'b1);
    send_tile(2, 4, 1'b0, 1'b1);
    idle(14);

    // both banks occupied: in_ready low for three cycles
    stalls = 0;
    send_tile(3, 4, 1'b0, 1'b1);
    send_tile(0, 1, 1'b0, 1'b1);
    send_tile(1, 1, 1'b1, 1'b1);
    idle(16);
    chk("busy_stalls", 32'(stalls), 32'(3));

    // flush a filling tile while another drains
    td_cnt = 0;
    send_tile(0, 4, 1'b0, 1'b1);
    send_beat(1, 0, 1'b0, 1'b0);
    send_beat(1, 1, 1'b0, 1'b0);
    flush = 1'b1;
    send_beat(1, 2, 1'b0, 1'b0);
    flush = 1'b0;
    chk("flush_in_ready", 32'(bus.in_ready), 32'(1));
    send_tile(2, 4, 1'b0, 1'b1);
    idle(14);
    chk("flush_done_cnt", 32'(td_cnt), 32'(2));

    // reset mid-drain
    send_tile(3, 4, 1'b0, 1'b1);
    idle(2);
    mon_en = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'(0));
    chk("mid_rst_out_data", 32'(out_data), 32'(0));
    chk("mid_rst_tile_done", 32'(tile_done), 32'(0));
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    ntiles = 0;
    last_start = -100;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'(1));
    mon_en = 1;
    td_cnt = 0;
    send_tile(2, 4, 1'b0, 1'b1);
    idle(10);
    chk("post_rst_done_cnt", 32'(td_cnt), 32'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
